mult_hi_lo_unit: RTL and testbench



---
 rtl/mult_hi_lo_unit.sv | 147 ++++++++++++++
 tb/tb_mult_hi_lo_unit.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_hi_lo_unit.sv
// ---------------------------------------------------------------------------
// mult_hi_lo_unit
//
// Iterative signed WIDTH x WIDTH shift-and-add multiplier that owns the
// architectural HI/LO register pair. A start pulse from the decoder
// (hi_lo_write) launches a multiply on the two register-file operands. The
// unit works on magnitudes and fixes the sign in one final cycle.
//
// Handshake: start is only looked at while the unit is idle (busy = 0). A
// start seen in that state is accepted on that clock edge. A start seen while
// busy is dropped and is not queued. When the result is written, done pulses
// for one cycle with busy already low, so a new start can be accepted in that
// same cycle.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   begin a multiply (sampled only in IDLE)
//   op_a       in   WIDTH  multiplicand (rs), two's complement
//   op_b       in   WIDTH  multiplier (rt), two's complement
//   sel_hi_lo  in   1 = read HI, 0 = read LO
//   busy       out  registered, high exactly in CALC and SIGN
//   done       out  one-cycle pulse after HI/LO were updated
//   hi_lo_out  out  WIDTH  combinational sel_hi_lo ? hi : lo
//   hi, lo     out  WIDTH  architectural HI/LO registers
//
// Configuration macro:
//   MULT_EARLY_TERM_EN  when defined, CALC ends as soon as the shifted
//                       multiplier is zero. Results are unchanged and only
//                       latency shrinks. When undefined, CALC always runs
//                       WIDTH iterations.
// ---------------------------------------------------------------------------
module mult_hi_lo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sel_hi_lo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_lo_out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]      LAST_ITER = CW'(WIDTH - 1);
    localparam logic [CW-1:0]      ONE_C     = CW'(1);
    localparam logic [WIDTH-1:0]   ONE_W     = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W    = (2*WIDTH)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               neg;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   mplier_shift;
    logic [2*WIDTH-1:0] result;
    logic               last_iter;

    // |x| of the most negative value wraps back to 2^(WIDTH-1). That value
    // is exactly the right unsigned magnitude, so it needs no special case.
    assign a_mag = op_a[WIDTH-1] ? (~op_a + ONE_W) : op_a;
    assign b_mag = op_b[WIDTH-1] ? (~op_b + ONE_W) : op_b;

    assign result    = neg ? (~acc + ONE_2W) : acc;
    assign hi_lo_out = sel_hi_lo ? hi : lo;

    // Next-state logic
    always_comb begin
        state_next   = state;
        mplier_shift = mplier >> 1;
        last_iter    = (cnt == LAST_ITER);
`ifdef MULT_EARLY_TERM_EN
        // Once no multiplier bits remain, further iterations add nothing.
        last_iter    = last_iter || (mplier_shift == '0);
`endif
        case (state)
            S_IDLE:  if (start)     state_next = S_CALC;
            S_CALC:  if (last_iter) state_next = S_SIGN;
            S_SIGN:                 state_next = S_IDLE;
            default:                state_next = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= state_next;
            // busy is registered from the next state so that it is high
            // exactly while the FSM sits in CALC or SIGN.
            busy  <= (state_next != S_IDLE);
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        neg    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                S_CALC: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier_shift;
                    cnt    <= cnt + ONE_C;
                end
                S_SIGN: begin
                    {hi, lo} <= result;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_hi_lo_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_hi_lo_unit
//
// Self-checking bench for mult_hi_lo_unit (WIDTH = 32). Each driven multiply
// pushes its reference product into exp_q. A monitor pops one entry on every
// done pulse and compares it with {hi, lo}. Scenario tasks also check latency,
// busy behaviour and known constant results inline.
// ---------------------------------------------------------------------------
module tb_mult_hi_lo_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   op_a = '0;
    logic [W-1:0]   op_b = '0;
    logic           sel_hi_lo = 1'b0;
    logic           busy;
    logic           done;
    logic [W-1:0]   hi_lo_out;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] sb_exp;

    mult_hi_lo_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .sel_hi_lo (sel_hi_lo),
        .busy      (busy),
        .done      (done),
        .hi_lo_out (hi_lo_out),
        .hi        (hi),
        .lo        (lo)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout sim time exceeded, run aborted");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic logic [2*W-1:0] model_mult(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    function automatic int exp_latency(input logic [W-1:0] b);
`ifdef MULT_EARLY_TERM_EN
        logic [W-1:0] m;
        int           len;
        m   = b[W-1] ? (~b + 32'd1) : b;
        len = 1;
        for (int i = 0; i < W; i++) if (m[i]) len = i + 1;
        return len + 2;
`else
        return W + 2;
`endif
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected_done got hi=%h lo=%h, no result expected", hi, lo);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({hi, lo} !== sb_exp) begin
                    tests_failed++;
                    $display("FAIL sb_result got %h expected %h", {hi, lo}, sb_exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a falling edge; start is taken on the next rising edge.
    task automatic drive_mult(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        exp_q.push_back(model_mult(a, b));
    endtask

    // Counts falling edges after drive_mult until done is seen. Operands are
    // scrambled after acceptance. If poke_at > 0, a spurious start is pulsed
    // at that count. lat = -1 means done never came.
    task automatic wait_done(input int poke_at, output int lat, output int busy_bad);
        bit found;
        found    = 1'b0;
        busy_bad = 0;
        lat      = -1;
        for (int n = 1; n <= 200 && !found; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                op_a  = $urandom;
                op_b  = $urandom;
            end
            if (poke_at > 0 && n == poke_at) begin
                start = 1'b1;
                op_a  = $urandom;
                op_b  = $urandom;
            end
            if (poke_at > 0 && n == poke_at + 1) start = 1'b0;
            if (done === 1'b1) begin
                found = 1'b1;
                lat   = n;
                if (busy !== 1'b0) busy_bad++;
            end else if (busy !== 1'b1) begin
                busy_bad++;
            end
        end
        start = 1'b0;
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run += 4;
        if (hi !== 32'h0)   begin tests_failed++; $display("FAIL reset_hi got %h expected 0", hi); end
        if (lo !== 32'h0)   begin tests_failed++; $display("FAIL reset_lo got %h expected 0", lo); end
        if (busy !== 1'b0)  begin tests_failed++; $display("FAIL reset_busy got %b expected 0", busy); end
        if (done !== 1'b0)  begin tests_failed++; $display("FAIL reset_done got %b expected 0", done); end
        start = 1'b1;
        op_a  = 32'd7;
        op_b  = 32'd3;
        repeat (3) begin
            @(negedge clk);
            tests_run += 2;
            if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_start_busy got %b expected 0", busy); end
            if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_start_done got %b expected 0", done); end
        end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL post_reset_busy got %b expected 0", busy); end
    endtask

    task automatic test_mixed_signs();
        int lat, bb;
        @(negedge clk);
        drive_mult(32'd7, 32'hFFFF_FFFD);
        wait_done(0, lat, bb);
        tests_run += 4;
        if (lat != exp_latency(32'hFFFF_FFFD)) begin tests_failed++; $display("FAIL mixed_latency got %0d expected %0d", lat, exp_latency(32'hFFFF_FFFD)); end
        if (bb != 0)            begin tests_failed++; $display("FAIL mixed_busy got %0d bad cycles expected 0", bb); end
        if (hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL mixed_hi got %h expected ffffffff", hi); end
        if (lo !== 32'hFFFF_FFEB) begin tests_failed++; $display("FAIL mixed_lo got %h expected ffffffeb", lo); end
    endtask

    task automatic test_corner();
        int lat, bb;
        @(negedge clk);
        drive_mult(32'h8000_0000, 32'h8000_0000);
        wait_done(0, lat, bb);
        tests_run += 3;
        if (lat != exp_latency(32'h8000_0000)) begin tests_failed++; $display("FAIL min_latency got %0d expected %0d", lat, exp_latency(32'h8000_0000)); end
        if (hi !== 32'h4000_0000) begin tests_failed++; $display("FAIL min_hi got %h expected 40000000", hi); end
        if (lo !== 32'h0)         begin tests_failed++; $display("FAIL min_lo got %h expected 0", lo); end
        @(negedge clk);
        drive_mult(32'hFFFF_FFFF, 32'd1);
        wait_done(0, lat, bb);
        tests_run += 3;
        if (lat != exp_latency(32'd1)) begin tests_failed++; $display("FAIL neg1_latency got %0d expected %0d", lat, exp_latency(32'd1)); end
        if (hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL neg1_hi got %h expected ffffffff", hi); end
        if (lo !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL neg1_lo got %h expected ffffffff", lo); end
    endtask

    task automatic test_start_ignored();
        int lat, bb;
        logic [2*W-1:0] want;
        want = model_mult(32'h0000_1234, 32'hFFFF_0003);
        @(negedge clk);
        drive_mult(32'h0000_1234, 32'hFFFF_0003);
        wait_done(5, lat, bb);
        tests_run += 3;
        if (lat != exp_latency(32'hFFFF_0003)) begin tests_failed++; $display("FAIL ignored_latency got %0d expected %0d", lat, exp_latency(32'hFFFF_0003)); end
        if (bb != 0)           begin tests_failed++; $display("FAIL ignored_busy got %0d bad cycles expected 0", bb); end
        if ({hi, lo} !== want) begin tests_failed++; $display("FAIL ignored_result got %h expected %h", {hi, lo}, want); end
        repeat (2) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL ignored_not_queued busy got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        @(negedge clk);
        drive_mult(32'h0BAD_F00D, 32'h7FFF_FFFF);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL mid_busy_before got %b expected 1", busy); end
        rst_n = 1'b0;
        @(negedge clk);
        tests_run += 4;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_busy got %b expected 0", busy); end
        if (hi !== 32'h0)  begin tests_failed++; $display("FAIL mid_reset_hi got %h expected 0", hi); end
        if (lo !== 32'h0)  begin tests_failed++; $display("FAIL mid_reset_lo got %h expected 0", lo); end
        if (done !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_done got %b expected 0", done); end
        rst_n = 1'b1;
        exp_q.delete();
        done_cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        tests_run++;
        if (done_cnt != 0) begin tests_failed++; $display("FAIL mid_reset_no_done got %0d pulses expected 0", done_cnt); end
    endtask

    task automatic test_readback();
        int lat, bb;
        @(negedge clk);
        drive_mult(32'h0001_0000, 32'h0001_0000);
        wait_done(0, lat, bb);
        sel_hi_lo = 1'b1;
        #1;
        tests_run++;
        if (hi_lo_out !== 32'h1) begin tests_failed++; $display("FAIL readback_hi got %h expected 1", hi_lo_out); end
        sel_hi_lo = 1'b0;
        #1;
        tests_run++;
        if (hi_lo_out !== 32'h0) begin tests_failed++; $display("FAIL readback_lo got %h expected 0", hi_lo_out); end
    endtask

    task automatic test_early_term();
        int lat, bb;
        @(negedge clk);
        drive_mult(32'd5, 32'd3);
        wait_done(0, lat, bb);
        tests_run += 2;
        if (lat != exp_latency(32'd3)) begin tests_failed++; $display("FAIL et3_latency got %0d expected %0d", lat, exp_latency(32'd3)); end
        if (lo !== 32'd15)             begin tests_failed++; $display("FAIL et3_lo got %h expected f", lo); end
        @(negedge clk);
        drive_mult(32'd123, 32'd0);
        wait_done(0, lat, bb);
        tests_run += 3;
        if (lat != exp_latency(32'd0)) begin tests_failed++; $display("FAIL et0_latency got %0d expected %0d", lat, exp_latency(32'd0)); end
        if (hi !== 32'h0) begin tests_failed++; $display("FAIL et0_hi got %h expected 0", hi); end
        if (lo !== 32'h0) begin tests_failed++; $display("FAIL et0_lo got %h expected 0", lo); end
    endtask

    task automatic test_back_to_back();
        int lat, bb;
        logic [W-1:0] a, b;
        @(negedge clk);
        drive_mult(32'd5, 32'd3);
        wait_done(0, lat, bb);
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = (i == 0) ? 32'hFFFF_FFFF : $urandom;
            // Still in the done cycle: the unit is idle and must take this start.
            drive_mult(a, b);
            wait_done(0, lat, bb);
            tests_run += 2;
            if (lat != exp_latency(b)) begin tests_failed++; $display("FAIL b2b_latency[%0d] got %0d expected %0d", i, lat, exp_latency(b)); end
            if (bb != 0)               begin tests_failed++; $display("FAIL b2b_busy[%0d] got %0d bad cycles expected 0", i, bb); end
        end
    endtask

    task automatic test_random();
        int lat, bb;
        logic [W-1:0] a, b;
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = 32'h7FFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(0, 15);
                1:       b = 32'hFFFF_FFFF - $urandom_range(0, 15);
                default: b = $urandom;
            endcase
            @(negedge clk);
            drive_mult(a, b);
            wait_done(0, lat, bb);
            tests_run++;
            if (lat != exp_latency(b)) begin tests_failed++; $display("FAIL rand_latency[%0d] got %0d expected %0d", i, lat, exp_latency(b)); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_mixed_signs();
        test_corner();
        test_start_ignored();
        test_reset_mid();
        test_readback();
        test_early_term();
        test_back_to_back();
        test_random();
        repeat (3) @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL sb_leftover got %0d entries expected 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
